// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state encoding,
// ID/EX default widths and control-bundle bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  // ID/EX boundary default geometry
  localparam int IDEX_CTRL_W = 11;
  localparam int IDEX_N_DATA = 5;
  localparam int IDEX_N_REG  = 2;

  // ID/EX control bundle bit positions (MSB RegDst .. LSB RegWrite)
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_JUMP     = 3;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUOP_HI = 8;
  localparam int CTRL_ALUSRC   = 9;
  localparam int CTRL_REGDST   = 10;

endpackage

// File: rtl/pipe_entry.sv
// Single payload register with load enable. rst clears the whole payload;
// bub clears only the top KILL_W bits (the control field) so a bubble
// reads as all-zero control while data/regs keep their last value.
module pipe_entry #(
  parameter int W      = 8,
  parameter int KILL_W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         bub,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // load wins over bubble; bubble zeroes control only
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (ld)  q <= d;
    else if (bub) q[W-1 -: KILL_W] <= '0;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake,
// synchronous flush (bubble insertion) and a saturating stall counter.
// Optional second (skid) entry enabled by defining PIPE_STAGE_SKID_EN,
// which makes in_ready a pure register output.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = 32,
  parameter int N_DATA = IDEX_N_DATA,
  parameter int REG_W  = 5,
  parameter int N_REG  = IDEX_N_REG,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic [N_DATA*DATA_W-1:0] data_in,
  input  logic [N_REG*REG_W-1:0]   regs_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic [N_DATA*DATA_W-1:0] data_out,
  output logic [N_REG*REG_W-1:0]   regs_out,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int PW = CTRL_W + N_REG*REG_W + N_DATA*DATA_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pipe_state_t   state, state_nx;
  logic          vld_q;
  logic          accept, pop;
  logic          main_ld, main_bub;
  logic [PW-1:0] in_pl, main_d, main_q;

  assign in_pl  = {ctrl_in, regs_in, data_in};
  assign accept = in_valid & in_ready & ~flush;
  assign pop    = vld_q & out_ready;

  assign out_valid                      = vld_q;
  assign {ctrl_out, regs_out, data_out} = main_q;

  pipe_entry #(.W(PW), .KILL_W(CTRL_W)) u_main (
    .clk (clk),
    .rst (rst),
    .ld  (main_ld),
    .bub (main_bub),
    .d   (main_d),
    .q   (main_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic          rdy_q;
  logic          skid_ld;
  logic [PW-1:0] skid_q;

  assign in_ready = rdy_q;

  pipe_entry #(.W(PW), .KILL_W(CTRL_W)) u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (skid_ld),
    .bub (1'b0),
    .d   (in_pl),
    .q   (skid_q)
  );

  // next-state and entry steering; flush overrides accept and pop
  always_comb begin
    state_nx = state;
    main_ld  = 1'b0;
    main_bub = 1'b0;
    main_d   = in_pl;
    skid_ld  = 1'b0;
    if (flush) begin
      state_nx = ST_EMPTY;
      main_bub = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          state_nx = ST_FULL;
          main_ld  = 1'b1;
        end
        ST_FULL: begin
          if (accept && pop) begin
            main_ld = 1'b1;
          end else if (accept) begin
            state_nx = ST_SKID;
            skid_ld  = 1'b1;
          end else if (pop) begin
            state_nx = ST_EMPTY;
            main_bub = 1'b1;
          end
        end
        ST_SKID: if (pop) begin
          state_nx = ST_FULL;
          main_ld  = 1'b1;
          main_d   = skid_q;
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  // state, output valid and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nx;
      vld_q <= (state_nx != ST_EMPTY);
      rdy_q <= (state_nx != ST_SKID);
    end
  end
`else
  // single entry: refill possible in the same cycle the beat leaves
  assign in_ready = ~vld_q | out_ready;

  // next-state and entry steering; flush overrides accept and pop
  always_comb begin
    state_nx = state;
    main_ld  = 1'b0;
    main_bub = 1'b0;
    main_d   = in_pl;
    if (flush) begin
      state_nx = ST_EMPTY;
      main_bub = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          state_nx = ST_FULL;
          main_ld  = 1'b1;
        end
        ST_FULL: begin
          if (accept) begin
            main_ld = 1'b1;
          end else if (pop) begin
            state_nx = ST_EMPTY;
            main_bub = 1'b1;
          end
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  // state and output valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      vld_q <= 1'b0;
    end else begin
      state <= state_nx;
      vld_q <= (state_nx != ST_EMPTY);
    end
  end
`endif

  // saturating count of cycles a held beat waits on downstream
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (vld_q && !out_ready && !flush && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule
